// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster timing shared by the sync generator and downstream VGA logic
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BACK_DEF = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BACK_DEF = 33;
    localparam bit SYNC_ACTIVE_DEF = 1'b0;
    localparam int SCREEN_WIDTH = H_VISIBLE_DEF;
    localparam int SCREEN_HEIGHT = V_VISIBLE_DEF;
    localparam int FRAME_COUNT_W = 8;

    function automatic int h_total(input int visible, input int front, input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int v_total(input int visible, input int front, input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// vga_sync_if: raster timing bundle from the sync generator to the VGA output stage
interface vga_sync_if;
    import vga_timing_pkg::*;
    logic h_sync;
    logic v_sync;
    logic display_enable;
    logic [31:0] column;
    logic [31:0] row;
    logic line_start;
    logic frame_start;
    logic [FRAME_COUNT_W-1:0] frame_count;
    modport master(output h_sync, v_sync, display_enable, column, row, line_start, frame_start, frame_count);
    modport slave(input h_sync, v_sync, display_enable, column, row, line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: modulo-MAX counter advancing when en is high, wrap strobes on the MAX-1 -> 0 step
module vga_axis_counter #(
    parameter int MAX = 800,
    localparam int W = $clog2(MAX)
) (
    input  logic         vga_clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);
    logic [W-1:0] count_q, count_d;
    always_comb begin
        wrap = en && (count_q == W'(MAX - 1));
        count_d = wrap ? '0 : count_q + W'(en);
    end
    always_ff @(posedge vga_clock) begin
        if (reset) count_q <= '0;
        else count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: raster counters plus a registered decode of sync, enable, strobes and frame count
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT = H_FRONT_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BACK = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT = V_FRONT_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BACK = V_BACK_DEF,
    parameter bit SYNC_ACTIVE = SYNC_ACTIVE_DEF
) (
    input logic       vga_clock,
    input logic       reset,
    vga_sync_if.master vga
);
    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END = VS_START + V_SYNC;
    logic [$clog2(H_TOTAL)-1:0] hc;
    logic [$clog2(V_TOTAL)-1:0] vc;
    logic h_wrap, v_wrap;
    logic [31:0] h, v;
    logic h_sync_q, h_sync_d, v_sync_q, v_sync_d, de_q, de_d;
    logic line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic frame_wrap_q, frame_wrap_d;
    logic [31:0] column_q, column_d, row_q, row_d;
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;

    vga_axis_counter #(.MAX(H_TOTAL)) u_h (.vga_clock(vga_clock), .reset(reset), .en(1'b1), .count(hc), .wrap(h_wrap));
    vga_axis_counter #(.MAX(V_TOTAL)) u_v (.vga_clock(vga_clock), .reset(reset), .en(h_wrap), .count(vc), .wrap(v_wrap));

    assign h = 32'(hc);
    assign v = 32'(vc);

    // frame_wrap_q marks the (0,0) cycle reached by wrapping, so the reset start does not count a frame
    always_comb begin
        de_d = (h < H_VISIBLE) && (v < V_VISIBLE);
        h_sync_d = (h >= HS_START && h < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        v_sync_d = (v >= VS_START && v < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        line_start_d = h == 0;
        frame_start_d = h == 0 && v == 0;
        frame_wrap_d = v_wrap;
        frame_count_d = frame_count_q + FRAME_COUNT_W'(frame_wrap_q);
        column_d = h;
        row_d = v;
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            h_sync_q <= ~SYNC_ACTIVE;
            v_sync_q <= ~SYNC_ACTIVE;
            de_q <= 1'b0;
            line_start_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_wrap_q <= 1'b0;
            frame_count_q <= '0;
            column_q <= '0;
            row_q <= '0;
        end else begin
            h_sync_q <= h_sync_d;
            v_sync_q <= v_sync_d;
            de_q <= de_d;
            line_start_q <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_wrap_q <= frame_wrap_d;
            frame_count_q <= frame_count_d;
            column_q <= column_d;
            row_q <= row_d;
        end
    end

    assign vga.h_sync = h_sync_q;
    assign vga.v_sync = v_sync_q;
    assign vga.display_enable = de_q;
    assign vga.line_start = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_count_q;
    assign vga.column = column_q;
    assign vga.row = row_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: directed checks of default, narrow-line, tiny-frame and active-high sync instances
module tb_vga_sync_generator;
    logic vga_clock = 1'b0;
    logic rst_full = 1'b1, rst_tall = 1'b1, rst_small = 1'b1, rst_pos = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 vga_clock = ~vga_clock;

    vga_sync_if if_full();
    vga_sync_if if_tall();
    vga_sync_if if_small();
    vga_sync_if if_pos();

    vga_sync_generator u_full (.vga_clock(vga_clock), .reset(rst_full), .vga(if_full));
    vga_sync_generator #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2)) u_tall (
        .vga_clock(vga_clock), .reset(rst_tall), .vga(if_tall));
    vga_sync_generator #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_small (
        .vga_clock(vga_clock), .reset(rst_small), .vga(if_small));
    vga_sync_generator #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b1)) u_pos (
        .vga_clock(vga_clock), .reset(rst_pos), .vga(if_pos));

    task automatic tick(input int n);
        repeat (n) @(posedge vga_clock);
        #1;
    endtask

    task automatic test_reset;
        tick(5);
        checks++; if (if_full.column !== 32'd0) begin errors++; $display("FAIL reset_column: got %0d want 0", if_full.column); end
        checks++; if (if_full.row !== 32'd0) begin errors++; $display("FAIL reset_row: got %0d want 0", if_full.row); end
        checks++; if (if_full.display_enable !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", if_full.display_enable); end
        checks++; if (if_full.line_start !== 1'b0) begin errors++; $display("FAIL reset_line_start: got %b want 0", if_full.line_start); end
        checks++; if (if_full.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", if_full.frame_start); end
        checks++; if (if_full.h_sync !== 1'b1) begin errors++; $display("FAIL reset_h_sync: got %b want 1", if_full.h_sync); end
        checks++; if (if_full.v_sync !== 1'b1) begin errors++; $display("FAIL reset_v_sync: got %b want 1", if_full.v_sync); end
        checks++; if (if_full.frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame_count: got %0d want 0", if_full.frame_count); end
        rst_full = 1'b0;
        tick(1);
        checks++; if (if_full.column !== 32'd0 || if_full.row !== 32'd0) begin errors++; $display("FAIL release_pos: got %0d,%0d want 0,0", if_full.column, if_full.row); end
        checks++; if (if_full.display_enable !== 1'b1) begin errors++; $display("FAIL release_de: got %b want 1", if_full.display_enable); end
        checks++; if (if_full.line_start !== 1'b1) begin errors++; $display("FAIL release_line_start: got %b want 1", if_full.line_start); end
        checks++; if (if_full.frame_start !== 1'b1) begin errors++; $display("FAIL release_frame_start: got %b want 1", if_full.frame_start); end
        checks++; if (if_full.frame_count !== 8'd0) begin errors++; $display("FAIL release_frame_count: got %0d want 0", if_full.frame_count); end
    endtask

    task automatic test_line_timing;
        int c;
        int hs_low = 0;
        int ls_cnt = 0;
        for (int n = 1; n <= 1600; n++) begin
            tick(1);
            c = n % 800;
            checks++; if (if_full.column !== 32'(c)) begin errors++; $display("FAIL line_column: got %0d want %0d", if_full.column, c); end
            checks++; if (if_full.display_enable !== 1'(c < 640)) begin errors++; $display("FAIL line_de at col %0d: got %b want %b", c, if_full.display_enable, c < 640); end
            checks++; if (if_full.h_sync !== 1'(!(c >= 656 && c < 752))) begin errors++; $display("FAIL line_h_sync at col %0d: got %b", c, if_full.h_sync); end
            checks++; if (if_full.line_start !== 1'(c == 0)) begin errors++; $display("FAIL line_start at col %0d: got %b", c, if_full.line_start); end
            hs_low += int'(if_full.h_sync === 1'b0);
            ls_cnt += int'(if_full.line_start === 1'b1);
        end
        checks++; if (hs_low != 192) begin errors++; $display("FAIL line_h_sync_width: got %0d want 192", hs_low); end
        checks++; if (ls_cnt != 2) begin errors++; $display("FAIL line_start_count: got %0d want 2", ls_cnt); end
        checks++; if (if_full.row !== 32'd2) begin errors++; $display("FAIL line_row: got %0d want 2", if_full.row); end
    endtask

    task automatic test_frame_timing;
        int c = 0;
        int r = 0;
        int vs_low = 0;
        logic prev_vs;
        rst_tall = 1'b0;
        tick(1);
        checks++; if (if_tall.frame_start !== 1'b1 || if_tall.frame_count !== 8'd0) begin errors++; $display("FAIL frame_first: got fs=%b fc=%0d want 1,0", if_tall.frame_start, if_tall.frame_count); end
        prev_vs = if_tall.v_sync;
        for (int n = 1; n <= 7350; n++) begin
            tick(1);
            c++;
            if (c == 14) begin c = 0; r = (r + 1) % 525; end
            checks++; if (if_tall.column !== 32'(c) || if_tall.row !== 32'(r)) begin errors++; $display("FAIL frame_pos: got %0d,%0d want %0d,%0d", if_tall.column, if_tall.row, c, r); end
            checks++; if (if_tall.display_enable !== 1'(c < 8 && r < 480)) begin errors++; $display("FAIL frame_de at %0d,%0d: got %b", c, r, if_tall.display_enable); end
            checks++; if (if_tall.v_sync !== 1'(!(r >= 490 && r < 492))) begin errors++; $display("FAIL frame_v_sync at row %0d: got %b", r, if_tall.v_sync); end
            checks++; if (if_tall.frame_start !== 1'(c == 0 && r == 0)) begin errors++; $display("FAIL frame_start at %0d,%0d: got %b", c, r, if_tall.frame_start); end
            checks++; if (if_tall.frame_count !== ((n == 7350) ? 8'd1 : 8'd0)) begin errors++; $display("FAIL frame_count at cycle %0d: got %0d", n, if_tall.frame_count); end
            checks++; if (if_tall.v_sync !== prev_vs && if_tall.column !== 32'd0) begin errors++; $display("FAIL frame_v_sync_edge: changed at column %0d want 0", if_tall.column); end
            prev_vs = if_tall.v_sync;
            vs_low += int'(if_tall.v_sync === 1'b0);
        end
        checks++; if (vs_low != 28) begin errors++; $display("FAIL frame_v_sync_width: got %0d want 28", vs_low); end
    endtask

    task automatic test_mid_sync_reset;
        tick(491 * 14 + 10);
        checks++; if (if_tall.row !== 32'd491 || if_tall.column !== 32'd10) begin errors++; $display("FAIL midsync_pos: got %0d,%0d want 10,491", if_tall.column, if_tall.row); end
        checks++; if (if_tall.h_sync !== 1'b0 || if_tall.v_sync !== 1'b0) begin errors++; $display("FAIL midsync_active: got h=%b v=%b want 0,0", if_tall.h_sync, if_tall.v_sync); end
        rst_tall = 1'b1;
        tick(1);
        checks++; if (if_tall.h_sync !== 1'b1 || if_tall.v_sync !== 1'b1) begin errors++; $display("FAIL midsync_reset_sync: got h=%b v=%b want 1,1", if_tall.h_sync, if_tall.v_sync); end
        checks++; if (if_tall.column !== 32'd0 || if_tall.row !== 32'd0 || if_tall.frame_count !== 8'd0) begin errors++; $display("FAIL midsync_reset_counts: got %0d,%0d,%0d want 0,0,0", if_tall.column, if_tall.row, if_tall.frame_count); end
        checks++; if (if_tall.display_enable !== 1'b0 || if_tall.frame_start !== 1'b0) begin errors++; $display("FAIL midsync_reset_flags: got de=%b fs=%b want 0,0", if_tall.display_enable, if_tall.frame_start); end
        rst_tall = 1'b0;
        tick(1);
        checks++; if (if_tall.display_enable !== 1'b1 || if_tall.frame_start !== 1'b1 || if_tall.line_start !== 1'b1) begin errors++; $display("FAIL midsync_restart_flags: got de=%b fs=%b ls=%b want 1,1,1", if_tall.display_enable, if_tall.frame_start, if_tall.line_start); end
        checks++; if (if_tall.frame_count !== 8'd0 || if_tall.column !== 32'd0 || if_tall.row !== 32'd0) begin errors++; $display("FAIL midsync_restart_counts: got %0d,%0d,%0d want 0,0,0", if_tall.column, if_tall.row, if_tall.frame_count); end
    endtask

    task automatic test_frame_wrap;
        rst_small = 1'b0;
        tick(1);
        checks++; if (if_small.frame_start !== 1'b1 || if_small.frame_count !== 8'd0) begin errors++; $display("FAIL wrap_first: got fs=%b fc=%0d want 1,0", if_small.frame_start, if_small.frame_count); end
        for (int k = 1; k <= 300; k++) begin
            tick(98);
            checks++; if (if_small.frame_start !== 1'b1) begin errors++; $display("FAIL wrap_frame_start frame %0d: got %b want 1", k, if_small.frame_start); end
            checks++; if (if_small.frame_count !== 8'(k)) begin errors++; $display("FAIL wrap_frame_count frame %0d: got %0d want %0d", k, if_small.frame_count, k % 256); end
        end
    endtask

    task automatic test_sync_polarity;
        int c = 0;
        int r = 0;
        checks++; if (if_pos.h_sync !== 1'b0 || if_pos.v_sync !== 1'b0) begin errors++; $display("FAIL pos_reset_idle: got h=%b v=%b want 0,0", if_pos.h_sync, if_pos.v_sync); end
        rst_pos = 1'b0;
        tick(1);
        checks++; if (if_pos.h_sync !== 1'b0 || if_pos.v_sync !== 1'b0 || if_pos.frame_start !== 1'b1) begin errors++; $display("FAIL pos_first: got h=%b v=%b fs=%b want 0,0,1", if_pos.h_sync, if_pos.v_sync, if_pos.frame_start); end
        for (int n = 1; n <= 98; n++) begin
            tick(1);
            c++;
            if (c == 14) begin c = 0; r = (r + 1) % 7; end
            checks++; if (if_pos.h_sync !== 1'(c >= 10 && c < 12)) begin errors++; $display("FAIL pos_h_sync at %0d,%0d: got %b", c, r, if_pos.h_sync); end
            checks++; if (if_pos.v_sync !== 1'(r == 5)) begin errors++; $display("FAIL pos_v_sync at %0d,%0d: got %b", c, r, if_pos.v_sync); end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_mid_sync_reset();
        test_frame_wrap();
        test_sync_polarity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
